// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: FSM states, opcodes,
// datapath mux select codes and the branch-condition helper.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_EXEC_R   = 4'd5,
    S_EXEC_I   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // blt relies on the ALU computing rs1-rs2, so the result sign is the less-than flag.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       zero_flag,
                                        input logic       sign_flag);
    case (funct3)
      F3_BEQ:  return zero_flag;
      F3_BNE:  return ~zero_flag;
      F3_BLT:  return sign_flag;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive memory wait cycles; flags the last allowed wait cycle so the
// controller can trap on the following edge.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Clear has priority, so a ready in the final wait cycle never reports expiry.
  assign expired = inc && !clr && (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory multi-cycle RV32 datapath, with a
// req/ready memory handshake and a sticky trap on illegal opcode or timeout.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       sign_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       trap,
  output logic [3:0] state_dbg
);
  import rv_ctrl_pkg::*;

  state_t state, state_next;
  logic   to_inc, to_clr, to_expired;

  assign to_inc = mem_req & ~mem_ready;
  assign to_clr = ~mem_req | mem_ready;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (to_inc),
    .clr    (to_clr),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)       state_next = S_DECODE;
        else if (to_expired) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)       state_next = S_WB_MEM;
        else if (to_expired) state_next = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)       state_next = S_FETCH;
        else if (to_expired) state_next = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // Outputs decode the state only, except the FETCH/BRANCH write strobes that
  // must land in the same cycle as the memory transfer or branch decision.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = RES_MDR;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = branch_taken(funct3, zero_flag, sign_flag);
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction flows, handshake waits,
// branch conditions, traps and reset behaviour.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WR   = 4'd4;
  localparam logic [3:0] S_EXEC_R   = 4'd5;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero_flag, sign_flag, mem_ready;
  logic       mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .trap(trap), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", state_dbg, S_FETCH);
    chk("rst_trap", 4'(trap), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                           input logic s, input logic exp_pc);
    opcode = 7'b1100011; funct3 = f3; mem_ready = 1'b1; zero_flag = 1'b0; sign_flag = 1'b0;
    cyc();
    cyc();
    zero_flag = z; sign_flag = s;
    #1;
    chk({tag, "_state"}, state_dbg, S_BRANCH);
    chk({tag, "_pcw"}, 4'(pc_write), 4'(exp_pc));
    cyc();
    chk({tag, "_back"}, state_dbg, S_FETCH);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    zero_flag = 1'b0; sign_flag = 1'b0; mem_ready = 1'b0;
    #3;
    // Reset values: FETCH decode with mem_ready low
    chk("reset_state", state_dbg, S_FETCH);
    chk("reset_req", 4'(mem_req), 4'd1);
    chk("reset_we", 4'(mem_we), 4'd0);
    chk("reset_addr", 4'(addr_src), 4'd0);
    chk("reset_irw", 4'(ir_write), 4'd0);
    chk("reset_pcw", 4'(pc_write), 4'd0);
    chk("reset_regw", 4'(reg_write), 4'd0);
    chk("reset_srca", 4'(alu_src_a), 4'd0);
    chk("reset_srcb", 4'(alu_src_b), 4'd2);
    chk("reset_aluop", 4'(alu_op), 4'd0);
    chk("reset_res", 4'(result_src), 4'd2);
    chk("reset_trap", 4'(trap), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type, zero-wait memory
    opcode = 7'b0110011; mem_ready = 1'b1;
    #1;
    chk("add_f_irw", 4'(ir_write), 4'd1);
    chk("add_f_pcw", 4'(pc_write), 4'd1);
    cyc();
    chk("add_dec", state_dbg, S_DECODE);
    chk("add_dec_srca", 4'(alu_src_a), 4'd1);
    chk("add_dec_srcb", 4'(alu_src_b), 4'd1);
    chk("add_dec_req", 4'(mem_req), 4'd0);
    chk("add_dec_irw", 4'(ir_write), 4'd0);
    cyc();
    chk("add_exec", state_dbg, S_EXEC_R);
    chk("add_exec_srca", 4'(alu_src_a), 4'd2);
    chk("add_exec_srcb", 4'(alu_src_b), 4'd0);
    chk("add_exec_op", 4'(alu_op), 4'd2);
    chk("add_exec_regw", 4'(reg_write), 4'd0);
    cyc();
    chk("add_wb", state_dbg, S_WB_ALU);
    chk("add_wb_regw", 4'(reg_write), 4'd1);
    chk("add_wb_res", 4'(result_src), 4'd0);
    cyc();
    chk("add_back", state_dbg, S_FETCH);
    chk("add_back_regw", 4'(reg_write), 4'd0);

    // lw with three wait cycles in MEM_RD
    opcode = 7'b0000011; mem_ready = 1'b1;
    cyc();
    chk("lw_dec", state_dbg, S_DECODE);
    mem_ready = 1'b0;
    cyc();
    chk("lw_addr", state_dbg, S_MEM_ADDR);
    chk("lw_addr_srca", 4'(alu_src_a), 4'd2);
    chk("lw_addr_srcb", 4'(alu_src_b), 4'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_ready = (i == 3);
      #1;
      chk("lw_rd_state", state_dbg, S_MEM_RD);
      chk("lw_rd_req", 4'(mem_req), 4'd1);
      chk("lw_rd_addr", 4'(addr_src), 4'd1);
      chk("lw_rd_we", 4'(mem_we), 4'd0);
    end
    cyc();
    chk("lw_wb", state_dbg, S_WB_MEM);
    chk("lw_wb_regw", 4'(reg_write), 4'd1);
    chk("lw_wb_res", 4'(result_src), 4'd1);
    cyc();
    chk("lw_back", state_dbg, S_FETCH);

    // Branch conditions
    do_branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1);
    do_branch("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
    do_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
    do_branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b1);
    do_branch("blt_s1", 3'b100, 1'b0, 1'b1, 1'b1);
    do_branch("blt_s0", 3'b100, 1'b1, 1'b0, 1'b0);
    do_branch("f3_010", 3'b010, 1'b1, 1'b1, 1'b0);
    do_branch("f3_001srcop", 3'b001, 1'b0, 1'b0, 1'b1);

    // sw, zero-wait
    opcode = 7'b0100011; mem_ready = 1'b1;
    cyc();
    cyc();
    chk("sw_addr", state_dbg, S_MEM_ADDR);
    cyc();
    chk("sw_wr", state_dbg, S_MEM_WR);
    chk("sw_wr_we", 4'(mem_we), 4'd1);
    chk("sw_wr_addr", 4'(addr_src), 4'd1);
    cyc();
    chk("sw_back", state_dbg, S_FETCH);

    // Illegal opcode -> sticky trap
    opcode = 7'b1110011; mem_ready = 1'b1;
    cyc();
    cyc();
    chk("ill_trap_state", state_dbg, S_TRAP);
    chk("ill_trap", 4'(trap), 4'd1);
    chk("ill_req", 4'(mem_req), 4'd0);
    repeat (20) cyc();
    chk("ill_hold_state", state_dbg, S_TRAP);
    chk("ill_hold_trap", 4'(trap), 4'd1);
    chk("ill_hold_req", 4'(mem_req), 4'd0);
    chk("ill_hold_irw", 4'(ir_write), 4'd0);
    chk("ill_hold_pcw", 4'(pc_write), 4'd0);
    mem_ready = 1'b0;
    do_reset();

    // Fetch timeout: 15 wait cycles -> TRAP on cycle 16
    for (int i = 1; i <= 15; i++) begin
      chk("to_wait_state", state_dbg, S_FETCH);
      cyc();
    end
    chk("to_trap_state", state_dbg, S_TRAP);
    chk("to_trap", 4'(trap), 4'd1);
    do_reset();

    // Ready on the 15th wait cycle wins over the timeout
    opcode = 7'b0110011;
    repeat (14) cyc();
    mem_ready = 1'b1;
    #1;
    chk("to15_state", state_dbg, S_FETCH);
    chk("to15_irw", 4'(ir_write), 4'd1);
    cyc();
    chk("to15_dec", state_dbg, S_DECODE);
    chk("to15_trap", 4'(trap), 4'd0);
    cyc();
    cyc();
    cyc();
    chk("to15_back", state_dbg, S_FETCH);

    // Reset in the middle of a stalled MEM_WR
    opcode = 7'b0100011; mem_ready = 1'b1;
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("mid_wr_state", state_dbg, S_MEM_WR);
    chk("mid_wr_we", 4'(mem_we), 4'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 4'(mem_we), 4'd0);
    chk("mid_rst_state", state_dbg, S_FETCH);
    chk("mid_rst_addr", 4'(addr_src), 4'd0);
    chk("mid_rst_req", 4'(mem_req), 4'd1);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 7'b0110011; mem_ready = 1'b1;
    #1;
    chk("post_rst_irw", 4'(ir_write), 4'd1);
    cyc();
    chk("post_rst_dec", state_dbg, S_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
